// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package disp_pkg;

    localparam int NUM_DIGITS_DEF = 6;
    localparam int DIGIT_W        = 3;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_ON    = 1'b1
    } scan_state_t;

    typedef logic [3:0] nibble_t;

    // Counter width able to hold the larger of the two terminal counts (min 1 bit).
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/disp_anode_dec.sv
// Digit index to active-low one-hot anode drive; all anodes off when not on.
module disp_anode_dec
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEF
) (
    input  logic                  on,
    input  logic [DIGIT_W-1:0]    idx,
    output logic [NUM_DIGITS-1:0] anode_n
);

    // Out-of-range indices match no bit, so they fall through to all-off.
    always_comb begin
        anode_n = '1;
        if (on) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx == DIGIT_W'(i)) anode_n[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed seven-segment scan sequencer with dead-time blanking and a
// frame-synchronous double-buffered display value.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int ON_CYC     = 100000,
    parameter int BLANK_CYC  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    lz_en,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic [2:0]              digit_sel,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [3:0]              digit_val,
    output logic                    digit_blank,
    output logic                    frame_done
);

    localparam int                 CNT_W      = cnt_width(ON_CYC, BLANK_CYC);
    localparam logic [CNT_W-1:0]   ON_LAST    = CNT_W'(ON_CYC - 1);
    localparam logic [CNT_W-1:0]   BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [DIGIT_W-1:0] SEL_LAST   = DIGIT_W'(NUM_DIGITS - 1);

    scan_state_t                   state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [DIGIT_W-1:0]            sel_q, sel_d;
    nibble_t [NUM_DIGITS-1:0]      active_q, active_d;
    nibble_t [NUM_DIGITS-1:0]      shadow_q, shadow_d;
    logic                          pending_q, pending_d;

    logic slot_end, wrap, xfer, commit, upper_zero;

    always_comb begin
        slot_end = (state_q == S_ON) && (cnt_q == ON_LAST);
        wrap     = en && slot_end && (sel_q == SEL_LAST);
        xfer     = load_valid && !pending_q;
        // While disabled there is no frame to tear, so commit right away.
        commit   = pending_q && (wrap || !en);
    end

    // Scan sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        if (!en) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            sel_d   = '0;
        end else begin
            case (state_q)
                S_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        cnt_d   = '0;
                        state_d = S_ON;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_ON: begin
                    if (slot_end) begin
                        cnt_d   = '0;
                        state_d = S_BLANK;
                        sel_d   = (sel_q == SEL_LAST) ? '0 : sel_q + DIGIT_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Double buffer; ready is low while pending, so commit and load never coincide.
    always_comb begin
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (commit) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else if (xfer) begin
            shadow_d  = load_data;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_BLANK;
            cnt_q     <= '0;
            sel_q     <= '0;
            active_q  <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
        end
    end

    // Digit readout and leading-zero suppression
    always_comb begin
        digit_val  = '0;
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_q == DIGIT_W'(i)) digit_val = active_q[i];
            if ((DIGIT_W'(i) >= sel_q) && (active_q[i] != 4'h0)) upper_zero = 1'b0;
        end
        digit_blank = !en || (state_q != S_ON) ||
                      (lz_en && (sel_q != '0) && upper_zero);
    end

    assign load_ready = !pending_q;
    assign frame_done = wrap;
    assign digit_sel  = sel_q;

    disp_anode_dec #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_anode_dec (
        .on      (state_q == S_ON),
        .idx     (sel_q),
        .anode_n (anode)
    );

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with 6 digits, 4 on-clocks, 2 blank-clocks.
module tb_disp_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, en, lz_en, load_valid, load_ready;
    logic [23:0] load_data;
    logic [2:0]  digit_sel;
    logic [5:0]  anode;
    logic [3:0]  digit_val;
    logic        digit_blank, frame_done;

    int checks = 0;
    int errors = 0;
    int ph     = 0;   // expected position within the 36-clock frame

    disp_scan_ctrl #(
        .NUM_DIGITS (6),
        .ON_CYC     (4),
        .BLANK_CYC  (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .lz_en       (lz_en),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .digit_sel   (digit_sel),
        .anode       (anode),
        .digit_val   (digit_val),
        .digit_blank (digit_blank),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
        ph = (ph + 1) % 36;
    endtask

    task automatic goto_ph(input int p);
        for (int i = 0; i < 36 && ph != p; i++) step();
    endtask

    task automatic offer(input logic [23:0] v);
        load_valid = 1'b1;
        load_data  = v;
        step();
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; lz_en = 1'b0; load_valid = 1'b0; load_data = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (anode !== 6'h3F) begin errors++; $display("FAIL rst_anode got %h exp 3f", anode); end
        checks++; if (digit_sel !== 3'd0) begin errors++; $display("FAIL rst_sel got %0d exp 0", digit_sel); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", load_ready); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got %b exp 0", frame_done); end
        checks++; if (digit_blank !== 1'b1) begin errors++; $display("FAIL rst_blank got %b exp 1", digit_blank); end
        checks++; if (digit_val !== 4'h0) begin errors++; $display("FAIL rst_val got %h exp 0", digit_val); end
        rst_n = 1'b1;
        en    = 1'b1;
        ph    = 0;
    endtask

    task automatic test_scan();
        logic [5:0] ea;
        logic       on;
        for (int c = 0; c < 72; c++) begin
            on = (ph % 6) >= 2;
            ea = 6'h3F;
            if (on) ea[ph / 6] = 1'b0;
            checks++; if (anode !== ea) begin errors++; $display("FAIL scan_anode ph %0d got %h exp %h", ph, anode, ea); end
            checks++; if (digit_sel !== 3'(ph / 6)) begin errors++; $display("FAIL scan_sel ph %0d got %0d exp %0d", ph, digit_sel, ph / 6); end
            checks++; if (frame_done !== (ph == 35)) begin errors++; $display("FAIL scan_frame_done ph %0d got %b", ph, frame_done); end
            checks++; if (digit_val !== 4'h0) begin errors++; $display("FAIL scan_val ph %0d got %h exp 0", ph, digit_val); end
            checks++; if (digit_blank !== !on) begin errors++; $display("FAIL scan_blank ph %0d got %b exp %b", ph, digit_blank, !on); end
            step();
        end
    endtask

    task automatic test_load();
        goto_ph(10);
        offer(24'h123456);
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL load_ready_drop got %b exp 0", load_ready); end
        goto_ph(20);
        checks++; if (digit_val !== 4'h0) begin errors++; $display("FAIL load_no_tear got %h exp 0", digit_val); end
        goto_ph(35);
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL load_frame_done got %b exp 1", frame_done); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL load_ready_at_wrap got %b exp 0", load_ready); end
        checks++; if (digit_val !== 4'h0) begin errors++; $display("FAIL load_val_at_wrap got %h exp 0", digit_val); end
        step();
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL load_ready_return got %b exp 1", load_ready); end
        checks++; if (digit_val !== 4'h6) begin errors++; $display("FAIL load_digit0 got %h exp 6", digit_val); end
        goto_ph(32);
        checks++; if (digit_sel !== 3'd5) begin errors++; $display("FAIL load_sel5 got %0d exp 5", digit_sel); end
        checks++; if (digit_val !== 4'h1) begin errors++; $display("FAIL load_digit5 got %h exp 1", digit_val); end
        checks++; if (anode !== 6'h1F) begin errors++; $display("FAIL load_anode5 got %h exp 1f", anode); end
    endtask

    task automatic test_back_to_back();
        goto_ph(20);
        load_valid = 1'b1;
        load_data  = 24'h654321;
        step();
        load_data  = 24'hDDDDDD;
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_low got %b exp 0", load_ready); end
        goto_ph(0);
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_high got %b exp 1", load_ready); end
        checks++; if (digit_val !== 4'h1) begin errors++; $display("FAIL b2b_first_d0 got %h exp 1", digit_val); end
        load_data = 24'h9ABCDE;
        step();
        load_valid = 1'b0;
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_taken got %b exp 0", load_ready); end
        goto_ph(32);
        checks++; if (digit_val !== 4'h6) begin errors++; $display("FAIL b2b_first_d5 got %h exp 6", digit_val); end
        goto_ph(0);
        checks++; if (digit_val !== 4'hE) begin errors++; $display("FAIL b2b_second_d0 got %h exp e", digit_val); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_end got %b exp 1", load_ready); end
        goto_ph(32);
        checks++; if (digit_val !== 4'h9) begin errors++; $display("FAIL b2b_second_d5 got %h exp 9", digit_val); end
    endtask

    task automatic test_lz();
        logic [23:0] vals [3];
        logic [23:0] v;
        logic        exp_b;
        vals[0] = 24'h000042;
        vals[1] = 24'h000000;
        vals[2] = 24'h400002;
        lz_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            v = vals[k];
            goto_ph(33);
            offer(v);
            goto_ph(0);
            for (int d = 0; d < 6; d++) begin
                goto_ph(6 * d + 3);
                exp_b = (d != 0) && ((v >> (4 * d)) == 24'h0);
                checks++; if (digit_sel !== 3'(d)) begin errors++; $display("FAIL lz_sel v %h got %0d exp %0d", v, digit_sel, d); end
                checks++; if (digit_blank !== exp_b) begin errors++; $display("FAIL lz_blank v %h d %0d got %b exp %b", v, d, digit_blank, exp_b); end
                checks++; if (digit_val !== v[4*d +: 4]) begin errors++; $display("FAIL lz_val v %h d %0d got %h exp %h", v, d, digit_val, v[4*d +: 4]); end
            end
        end
        lz_en = 1'b0;
    endtask

    task automatic test_en();
        goto_ph(20);
        offer(24'h777777);
        checks++; if (anode !== 6'h37) begin errors++; $display("FAIL en_anode_d3 got %h exp 37", anode); end
        en = 1'b0;
        #1;
        checks++; if (digit_blank !== 1'b1) begin errors++; $display("FAIL en_blank got %b exp 1", digit_blank); end
        step();
        checks++; if (anode !== 6'h3F) begin errors++; $display("FAIL en_anode_off got %h exp 3f", anode); end
        checks++; if (digit_sel !== 3'd0) begin errors++; $display("FAIL en_sel got %0d exp 0", digit_sel); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL en_frame_done got %b exp 0", frame_done); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL en_commit_ready got %b exp 1", load_ready); end
        checks++; if (digit_val !== 4'h7) begin errors++; $display("FAIL en_commit_val got %h exp 7", digit_val); end
        step();
        checks++; if (anode !== 6'h3F) begin errors++; $display("FAIL en_hold_anode got %h exp 3f", anode); end
        en = 1'b1;
        ph = 0;
        step();
        checks++; if (anode !== 6'h3F) begin errors++; $display("FAIL en_restart_blank got %h exp 3f", anode); end
        step();
        checks++; if (anode !== 6'h3E) begin errors++; $display("FAIL en_restart_anode got %h exp 3e", anode); end
        checks++; if (digit_blank !== 1'b0) begin errors++; $display("FAIL en_restart_blank_flag got %b exp 0", digit_blank); end
        checks++; if (digit_val !== 4'h7) begin errors++; $display("FAIL en_restart_val got %h exp 7", digit_val); end
    endtask

    task automatic test_rst_mid();
        goto_ph(10);
        offer(24'h888888);
        goto_ph(14);
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL rstm_pending got %b exp 0", load_ready); end
        rst_n = 1'b0;
        #2;
        checks++; if (anode !== 6'h3F) begin errors++; $display("FAIL rstm_anode got %h exp 3f", anode); end
        checks++; if (digit_sel !== 3'd0) begin errors++; $display("FAIL rstm_sel got %0d exp 0", digit_sel); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rstm_ready got %b exp 1", load_ready); end
        checks++; if (digit_blank !== 1'b1) begin errors++; $display("FAIL rstm_blank got %b exp 1", digit_blank); end
        checks++; if (digit_val !== 4'h0) begin errors++; $display("FAIL rstm_val got %h exp 0", digit_val); end
        #1;
        rst_n = 1'b1;
        ph    = 0;
        goto_ph(2);
        checks++; if (anode !== 6'h3E) begin errors++; $display("FAIL rstm_anode_after got %h exp 3e", anode); end
        checks++; if (digit_val !== 4'h0) begin errors++; $display("FAIL rstm_val_after got %h exp 0", digit_val); end
        goto_ph(0);
        goto_ph(2);
        checks++; if (digit_val !== 4'h0) begin errors++; $display("FAIL rstm_discarded got %h exp 0", digit_val); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rstm_ready_after got %b exp 1", load_ready); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_back_to_back();
        test_lz();
        test_en();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
